// File: rtl/fetch_ex_queue.sv
// DEPTH-entry fetch->execute instruction queue with valid/ready handshakes and single-cycle flush.
// Optional same-cycle pass-through on an empty queue when FETCH_EX_QUEUE_BYPASS_EN is defined.
module fetch_ex_queue #(
    parameter int DEPTH     = 2,
    parameter int WORD_SIZE = 32
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic                         flush,
    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic [WORD_SIZE-1:0]         enq_pc,
    input  logic [WORD_SIZE-1:0]         enq_instr,
    input  logic [WORD_SIZE-1:0]         enq_prediction,
    output logic                         deq_valid,
    input  logic                         deq_ready,
    output logic [WORD_SIZE-1:0]         deq_pc,
    output logic [WORD_SIZE-1:0]         deq_pc4,
    output logic [WORD_SIZE-1:0]         deq_instr,
    output logic [WORD_SIZE-1:0]         deq_prediction,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WORD_SIZE-1:0] pcMem_q    [DEPTH];
    logic [WORD_SIZE-1:0] pc4Mem_q   [DEPTH];
    logic [WORD_SIZE-1:0] instrMem_q [DEPTH];
    logic [WORD_SIZE-1:0] predMem_q  [DEPTH];

    logic [PW-1:0] rdPtr_q, rdPtr_d;
    logic [PW-1:0] wrPtr_q, wrPtr_d;
    logic [CW-1:0] count_q, count_d;

    logic                 storedValid;
    logic                 bypass;
    logic                 enqFire;
    logic                 deqFire;
    logic [WORD_SIZE-1:0] enqPc4;

    assign enqPc4      = enq_pc + WORD_SIZE'(4);
    assign enq_ready   = !RST && !flush && (count_q < CW'(DEPTH));
    assign storedValid = !RST && !flush && (count_q != '0);

`ifdef FETCH_EX_QUEUE_BYPASS_EN
    assign bypass = !RST && !flush && (count_q == '0) && enq_valid && deq_ready;
`else
    assign bypass = 1'b0;
`endif

    assign deq_valid = storedValid || bypass;
    // A bypassed entry is consumed directly, so it is neither written nor counted.
    assign enqFire   = enq_valid && enq_ready && !bypass;
    assign deqFire   = storedValid && deq_ready;
    assign count     = count_q;

    always_comb begin
        deq_pc         = '0;
        deq_pc4        = '0;
        deq_instr      = '0;
        deq_prediction = '0;
        if (bypass) begin
            deq_pc         = enq_pc;
            deq_pc4        = enqPc4;
            deq_instr      = enq_instr;
            deq_prediction = enq_prediction;
        end else if (storedValid) begin
            deq_pc         = pcMem_q[rdPtr_q];
            deq_pc4        = pc4Mem_q[rdPtr_q];
            deq_instr      = instrMem_q[rdPtr_q];
            deq_prediction = predMem_q[rdPtr_q];
        end
    end

    always_comb begin
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (enqFire) wrPtr_d = wrPtr_q + PW'(1);
        if (deqFire) rdPtr_d = rdPtr_q + PW'(1);
        if (enqFire && !deqFire)      count_d = count_q + CW'(1);
        else if (!enqFire && deqFire) count_d = count_q - CW'(1);
        if (flush) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                pcMem_q[i]    <= '0;
                pc4Mem_q[i]   <= '0;
                instrMem_q[i] <= '0;
                predMem_q[i]  <= '0;
            end
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
            if (enqFire) begin
                pcMem_q[wrPtr_q]    <= enq_pc;
                pc4Mem_q[wrPtr_q]   <= enqPc4;
                instrMem_q[wrPtr_q] <= enq_instr;
                predMem_q[wrPtr_q]  <= enq_prediction;
            end
        end
    end

endmodule

// File: tb/tb_fetch_ex_queue.sv
// Directed self-checking bench for fetch_ex_queue at DEPTH = 4.
// Expected values are hand-computed; the bypass section follows FETCH_EX_QUEUE_BYPASS_EN.
module tb_fetch_ex_queue;

    localparam int DEPTH = 4;
    localparam int WS    = 32;

    logic          CLK = 1'b0;
    logic          RST;
    logic          flush;
    logic          enq_valid;
    logic          enq_ready;
    logic [WS-1:0] enq_pc;
    logic [WS-1:0] enq_instr;
    logic [WS-1:0] enq_prediction;
    logic          deq_valid;
    logic          deq_ready;
    logic [WS-1:0] deq_pc;
    logic [WS-1:0] deq_pc4;
    logic [WS-1:0] deq_instr;
    logic [WS-1:0] deq_prediction;
    logic [2:0]    count;

    int checks = 0;
    int errors = 0;

    fetch_ex_queue #(.DEPTH(DEPTH), .WORD_SIZE(WS)) dut (
        .CLK            (CLK),
        .RST            (RST),
        .flush          (flush),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .enq_pc         (enq_pc),
        .enq_instr      (enq_instr),
        .enq_prediction (enq_prediction),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .deq_pc         (deq_pc),
        .deq_pc4        (deq_pc4),
        .deq_instr      (deq_instr),
        .deq_prediction (deq_prediction),
        .count          (count)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Inputs change 1 time unit after the clock edge and settle before outputs are sampled.
    task automatic applyStimulus(input logic rst, input logic fl, input logic ev,
                                 input logic [WS-1:0] pc, input logic [WS-1:0] instr,
                                 input logic [WS-1:0] pred, input logic dr);
        RST            = rst;
        flush          = fl;
        enq_valid      = ev;
        enq_pc         = pc;
        enq_instr      = instr;
        enq_prediction = pred;
        deq_ready      = dr;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        // Reset held for two edges while fetch is already presenting.
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h900, 32'h1, 32'h2, 1'b0);
        checkOutput("rst_enq_ready", {31'd0, enq_ready}, 32'd0);
        checkOutput("rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        tick();
        tick();
        checkOutput("rst_count", {29'd0, count}, 32'd0);
        checkOutput("rst_enq_ready2", {31'd0, enq_ready}, 32'd0);

        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("post_rst_enq_ready", {31'd0, enq_ready}, 32'd1);
        checkOutput("post_rst_deq_valid", {31'd0, deq_valid}, 32'd0);
        checkOutput("post_rst_count", {29'd0, count}, 32'd0);
        checkOutput("post_rst_deq_pc", deq_pc, 32'd0);
        checkOutput("post_rst_deq_pc4", deq_pc4, 32'd0);
        checkOutput("post_rst_deq_instr", deq_instr, 32'd0);
        checkOutput("post_rst_deq_pred", deq_prediction, 32'd0);

        // Fill with deq_ready low.
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h100 + 32'(4*i), 32'hA000_0000 + 32'(i),
                          32'hB000_0000 + 32'(i), 1'b0);
            checkOutput($sformatf("fill_enq_ready_%0d", i), {31'd0, enq_ready}, 32'd1);
            if (i == 0) checkOutput("latency_deq_valid_before", {31'd0, deq_valid}, 32'd0);
            tick();
            checkOutput($sformatf("fill_count_%0d", i), {29'd0, count}, 32'(i + 1));
            if (i == 0) checkOutput("latency_deq_valid_after", {31'd0, deq_valid}, 32'd1);
        end

        applyStimulus(1'b0, 1'b0, 1'b1, 32'h110, 32'hDEAD, 32'hBEEF, 1'b0);
        checkOutput("full_enq_ready", {31'd0, enq_ready}, 32'd0);
        tick();
        checkOutput("full_fifth_rejected_count", {29'd0, count}, 32'd4);

        // Full with a simultaneous dequeue: only the dequeue fires.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h110, 32'hDEAD, 32'hBEEF, 1'b1);
        checkOutput("full_deq_enq_ready", {31'd0, enq_ready}, 32'd0);
        checkOutput("full_deq_valid", {31'd0, deq_valid}, 32'd1);
        checkOutput("full_deq_pc", deq_pc, 32'h100);
        checkOutput("full_deq_pc4", deq_pc4, 32'h104);
        checkOutput("full_deq_instr", deq_instr, 32'hA000_0000);
        checkOutput("full_deq_pred", deq_prediction, 32'hB000_0000);
        tick();
        checkOutput("full_deq_count", {29'd0, count}, 32'd3);

        for (int i = 1; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
            checkOutput($sformatf("drain_pc_%0d", i), deq_pc, 32'h100 + 32'(4*i));
            checkOutput($sformatf("drain_pc4_%0d", i), deq_pc4, 32'h104 + 32'(4*i));
            checkOutput($sformatf("drain_instr_%0d", i), deq_instr, 32'hA000_0000 + 32'(i));
            checkOutput($sformatf("drain_pred_%0d", i), deq_prediction, 32'hB000_0000 + 32'(i));
            tick();
            checkOutput($sformatf("drain_count_%0d", i), {29'd0, count}, 32'(DEPTH - 1 - i));
        end
        checkOutput("empty_deq_valid", {31'd0, deq_valid}, 32'd0);
        checkOutput("empty_deq_pc", deq_pc, 32'd0);

        // Steady occupancy of two across several pointer wraps.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h300 + 32'(4*i), 32'hC000_0000 + 32'(i), 32'h0, 1'b0);
            tick();
        end
        checkOutput("wrap_start_count", {29'd0, count}, 32'd2);
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 32'h308 + 32'(4*k), 32'hC000_0002 + 32'(k), 32'h0, 1'b1);
            checkOutput($sformatf("wrap_pc_%0d", k), deq_pc, 32'h300 + 32'(4*k));
            checkOutput($sformatf("wrap_instr_%0d", k), deq_instr, 32'hC000_0000 + 32'(k));
            tick();
            checkOutput($sformatf("wrap_count_%0d", k), {29'd0, count}, 32'd2);
        end

        // Bring occupancy to three, then flush with both handshakes requested.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h330, 32'h0, 32'h0, 1'b0);
        tick();
        checkOutput("preflush_count", {29'd0, count}, 32'd3);
        checkOutput("preflush_head", deq_pc, 32'h328);
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h400, 32'h0, 32'h0, 1'b1);
        checkOutput("flush_deq_valid", {31'd0, deq_valid}, 32'd0);
        checkOutput("flush_enq_ready", {31'd0, enq_ready}, 32'd0);
        checkOutput("flush_deq_pc", deq_pc, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("postflush_count", {29'd0, count}, 32'd0);
        checkOutput("postflush_deq_valid", {31'd0, deq_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h200, 32'h77, 32'h88, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("postflush_pc", deq_pc, 32'h200);
        checkOutput("postflush_pc4", deq_pc4, 32'h204);
        checkOutput("postflush_count1", {29'd0, count}, 32'd1);
        tick();
        checkOutput("postflush_drained", {29'd0, count}, 32'd0);

        // pc4 wraps to zero at the top of the address space.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h11, 32'h22, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("ovf_pc", deq_pc, 32'hFFFF_FFFC);
        checkOutput("ovf_pc4", deq_pc4, 32'h0000_0000);
        tick();
        checkOutput("ovf_count", {29'd0, count}, 32'd0);

        // Empty queue with both handshakes asserted.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h500, 32'h55, 32'h66, 1'b1);
`ifdef FETCH_EX_QUEUE_BYPASS_EN
        checkOutput("byp_deq_valid", {31'd0, deq_valid}, 32'd1);
        checkOutput("byp_deq_pc", deq_pc, 32'h500);
        checkOutput("byp_deq_pc4", deq_pc4, 32'h504);
        checkOutput("byp_deq_instr", deq_instr, 32'h55);
        tick();
        checkOutput("byp_count", {29'd0, count}, 32'd0);
`else
        checkOutput("nobyp_deq_valid_now", {31'd0, deq_valid}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b1);
        checkOutput("nobyp_count", {29'd0, count}, 32'd1);
        checkOutput("nobyp_deq_valid_next", {31'd0, deq_valid}, 32'd1);
        checkOutput("nobyp_deq_pc", deq_pc, 32'h500);
        tick();
        checkOutput("nobyp_drained", {29'd0, count}, 32'd0);
`endif

        // Reset mid-stream gates the handshakes immediately.
        applyStimulus(1'b0, 1'b0, 1'b1, 32'h600, 32'h0, 32'h0, 1'b0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 32'h604, 32'h0, 32'h0, 1'b1);
        checkOutput("midrst_deq_valid", {31'd0, deq_valid}, 32'd0);
        checkOutput("midrst_enq_ready", {31'd0, enq_ready}, 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
        checkOutput("midrst_count", {29'd0, count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
